// File: rtl/arb_ctrl_pkg.sv
// Shared types and defaults for the requester-side arbiter grant controller.
package arb_ctrl_pkg;

  localparam int N_CLIENTS     = 4;
  localparam int PTR_W         = 2;
  localparam int DEF_LEN_W     = 4;
  localparam int DEF_GUARD_CYC = 4;
  localparam int DEF_TIMEOUT   = 64;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_GRANT = 2'd1,
    OWN        = 2'd2,
    GUARD      = 2'd3
  } state_e;

  // One shared counter serves the burst, guard and timeout phases; size it for the largest.
  function automatic int cnt_width(input int len_w, input int guard_cyc, input int timeout);
    int m;
    m = (1 << len_w) - 1;
    if (guard_cyc - 1 > m) m = guard_cyc - 1;
    if (timeout - 1 > m) m = timeout - 1;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/arb_grant_decode.sv
// Qualifies a raw arbiter grant against the pending set and classifies it.
module arb_grant_decode
  import arb_ctrl_pkg::*;
(
  input  logic [N_CLIENTS-1:0] i_grant,
  input  logic [N_CLIENTS-1:0] i_pending,
  output logic                 o_take,
  output logic [PTR_W-1:0]     o_idx,
  output logic                 o_multi,
  output logic                 o_stray
);

  logic [N_CLIENTS-1:0] w_g;

  always_comb begin
    w_g    = i_grant & i_pending;
    o_take = |w_g;
    o_idx  = '0;
    // Scan downward so the lowest set bit wins.
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (w_g[i]) o_idx = PTR_W'(i);
    end
    o_multi = ($countones(i_grant) > 1);
    o_stray = (|i_grant) && !o_take;
  end

endmodule

// File: rtl/arb_grant_ctrl.sv
// Queues one job per client, requests the arbiter, owns the resource for the
// granted burst, then flushes the arbiter pipeline before requesting again.
module arb_grant_ctrl
  import arb_ctrl_pkg::*;
#(
  parameter int LEN_W     = DEF_LEN_W,
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CLIENTS-1:0]       job_valid,
  input  logic [N_CLIENTS*LEN_W-1:0] job_len,
  output logic [N_CLIENTS-1:0]       job_ready,
  output logic [N_CLIENTS-1:0]       req,
  output logic [PTR_W-1:0]           ptr,
  input  logic [N_CLIENTS-1:0]       grant,
  output logic                       owner_valid,
  output logic [PTR_W-1:0]           owner_id,
  output logic                       beat,
  output logic                       done,
  output logic                       grant_err,
  output logic                       timeout,
  output logic [1:0]                 dbg_state
);

  localparam int                CNT_W    = cnt_width(LEN_W, GUARD_CYC, TIMEOUT);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  GRD_LAST = CNT_W'(GUARD_CYC - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [N_CLIENTS-1:0]   r_pending;
  logic [LEN_W-1:0]       r_len_q [N_CLIENTS];
  logic [CNT_W-1:0]       r_cnt;
  logic [N_CLIENTS-1:0]   r_req;
  logic [PTR_W-1:0]       r_ptr;
  logic                   r_owner_valid;
  logic [PTR_W-1:0]       r_owner_id;

  logic [N_CLIENTS-1:0]   w_accept;
  logic [N_CLIENTS-1:0]   w_clr;
  logic [N_CLIENTS-1:0]   w_pending_nxt;
  logic                   w_take;
  logic [PTR_W-1:0]       w_idx;
  logic                   w_multi;
  logic                   w_stray;
  logic                   w_last;
  logic                   w_err;
  logic                   w_timeout;

  arb_grant_decode u_decode (
    .i_grant   (grant),
    .i_pending (r_pending),
    .o_take    (w_take),
    .o_idx     (w_idx),
    .o_multi   (w_multi),
    .o_stray   (w_stray)
  );

  // Job handshake: client i's job is accepted on the edge where job_valid[i] &&
  // job_ready[i]; job_ready[i] is low for as long as that client's job is pending.
  always_comb begin
    w_accept      = job_valid & ~r_pending;
    w_last        = (r_state == OWN) && (r_cnt == '0);
    w_clr         = w_last ? ({{(N_CLIENTS-1){1'b0}}, 1'b1} << r_owner_id) : '0;
    w_pending_nxt = (r_pending & ~w_clr) | w_accept;
    w_err         = (r_state == WAIT_GRANT) && (w_multi || w_stray);
    // An error cycle defers the timeout by one cycle so the pulses never overlap.
    w_timeout     = (r_state == WAIT_GRANT) && !w_take && !w_err && (r_cnt == TMO_LAST);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:       if (|r_pending) w_state_nxt = WAIT_GRANT;
      WAIT_GRANT: begin
        if (w_take)         w_state_nxt = OWN;
        else if (w_timeout) w_state_nxt = GUARD;
      end
      OWN:        if (w_last) w_state_nxt = GUARD;
      GUARD:      if (r_cnt == GRD_LAST) w_state_nxt = (|r_pending) ? WAIT_GRANT : IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_req     <= '0;
      for (int i = 0; i < N_CLIENTS; i++) r_len_q[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_req     <= (w_state_nxt == WAIT_GRANT) ? w_pending_nxt : '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (w_accept[i]) r_len_q[i] <= job_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        WAIT_GRANT: begin
          if (w_take)                 r_cnt <= CNT_W'(r_len_q[w_idx]);
          else if (w_timeout)         r_cnt <= '0;
          else if (r_cnt != TMO_LAST) r_cnt <= r_cnt + CNT_W'(1);
        end
        OWN:     r_cnt <= w_last ? '0 : r_cnt - CNT_W'(1);
        GUARD:   r_cnt <= (r_cnt == GRD_LAST) ? '0 : r_cnt + CNT_W'(1);
        default: r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_valid <= 1'b0;
      r_owner_id    <= '0;
      r_ptr         <= '0;
    end else if ((r_state == WAIT_GRANT) && w_take) begin
      r_owner_valid <= 1'b1;
      r_owner_id    <= w_idx;
    end else if (w_last) begin
      r_owner_valid <= 1'b0;
      r_ptr         <= r_owner_id + PTR_W'(1);
    end
  end

  assign job_ready   = ~r_pending;
  assign req         = r_req;
  assign ptr         = r_ptr;
  assign owner_valid = r_owner_valid;
  assign owner_id    = r_owner_id;
  assign beat        = (r_state == OWN);
  assign done        = w_last;
  assign grant_err   = w_err;
  assign timeout     = w_timeout;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_arb_grant_ctrl.sv
// Directed bench for arb_grant_ctrl: the bench plays the arbiter by hand.
module tb_arb_grant_ctrl;
  import arb_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  job_valid;
  logic [15:0] job_len;
  logic [3:0]  job_ready;
  logic [3:0]  req;
  logic [1:0]  ptr;
  logic [3:0]  grant;
  logic        owner_valid;
  logic [1:0]  owner_id;
  logic        beat;
  logic        done;
  logic        grant_err;
  logic        timeout;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  arb_grant_ctrl #(.LEN_W(4), .GUARD_CYC(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .job_valid   (job_valid),
    .job_len     (job_len),
    .job_ready   (job_ready),
    .req         (req),
    .ptr         (ptr),
    .grant       (grant),
    .owner_valid (owner_valid),
    .owner_id    (owner_id),
    .beat        (beat),
    .done        (done),
    .grant_err   (grant_err),
    .timeout     (timeout),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tmo_at;
    int n_done;
    rst_n     = 1'b1;
    job_valid = '0;
    job_len   = '0;
    grant     = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", req, 4'b0000);
    check("rst_ptr_owner", {ptr, owner_valid, owner_id}, 5'b0);
    check("rst_pulses", {beat, done, grant_err, timeout}, 4'b0);
    check("rst_ready", job_ready, 4'b1111);
    check("rst_state", dbg_state, IDLE);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single job on client 2, len 2, granted three cycles after req.
    job_len[8 +: 4] = 4'd2;
    job_valid = 4'b0100;
    #1 check("t1_ready_pre", job_ready, 4'b1111);
    step();
    job_valid = '0;
    check("t1_ready_pend", job_ready, 4'b1011);
    check("t1_idle_req", req, 4'b0000);
    step();
    check("t1_wait_state", dbg_state, WAIT_GRANT);
    check("t1_req", req, 4'b0100);
    step(); step();
    grant = 4'b0100;
    #1 check("t1_no_err", grant_err, 1'b0);
    check("t1_no_owner_yet", owner_valid, 1'b0);
    step();
    grant = '0;
    check("t1_owner", {owner_valid, owner_id}, 3'b110);
    check("t1_own_req", req, 4'b0000);
    check("t1_beat1", {beat, done}, 2'b10);
    step();
    check("t1_beat2", {beat, done}, 2'b10);
    step();
    check("t1_beat3", {beat, done}, 2'b11);
    check("t1_ready_on_done", job_ready[2], 1'b0);
    step();
    check("t1_after_burst", {beat, owner_valid}, 2'b00);
    check("t1_ptr", ptr, 2'd3);
    check("t1_ready_back", job_ready, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      check("t1_guard", dbg_state, GUARD);
      step();
    end
    check("t1_idle", dbg_state, IDLE);

    // Wrap and fairness: clients 3 and 0, len 0 each.
    job_len[12 +: 4] = 4'd0;
    job_len[0 +: 4]  = 4'd0;
    job_valid = 4'b1001;
    step();
    job_valid = '0;
    step();
    check("t2_req", req, 4'b1001);
    grant = 4'b1000;
    #1 check("t2_no_err", grant_err, 1'b0);
    step();
    grant = '0;
    check("t2_own3", {owner_valid, owner_id}, 3'b111);
    check("t2_one_beat3", {beat, done}, 2'b11);
    step();
    check("t2_ptr_wrap", ptr, 2'd0);
    check("t2_ready", job_ready, 4'b1110);
    step(); step(); step(); step();
    check("t2_wait_again", dbg_state, WAIT_GRANT);
    check("t2_req0", req, 4'b0001);
    grant = 4'b0001;
    step();
    grant = '0;
    check("t2_own0", {owner_valid, owner_id}, 3'b100);
    check("t2_one_beat0", {beat, done}, 2'b11);
    step();
    check("t2_ptr1", ptr, 2'd1);
    step(); step(); step(); step();
    check("t2_idle", dbg_state, IDLE);

    // Stale then malformed grant with only client 1 pending.
    job_len[4 +: 4] = 4'd1;
    job_valid = 4'b0010;
    step();
    job_valid = '0;
    step();
    check("t3_req", req, 4'b0010);
    grant = 4'b1000;
    #1 check("t3_stray_err", {grant_err, timeout}, 2'b10);
    step();
    check("t3_still_wait", {dbg_state, owner_valid}, {WAIT_GRANT, 1'b0});
    grant = 4'b0110;
    #1 check("t3_multi_err", grant_err, 1'b1);
    step();
    check("t3_owner1", {owner_valid, owner_id}, 3'b101);

    // Guard flush: grant to client 0 held through OWN and all of GUARD.
    grant = 4'b0001;
    job_len[0 +: 4] = 4'd3;
    job_valid = 4'b0001;
    #1 check("t4_own_no_err", grant_err, 1'b0);
    step();
    job_valid = '0;
    check("t4_last_beat", {beat, done, grant_err, owner_id}, 5'b11001);
    step();
    check("t4_ptr2", ptr, 2'd2);
    for (int i = 0; i < 4; i++) begin
      check("t4_guard_state", dbg_state, GUARD);
      check("t4_guard_quiet", {req, grant_err, owner_valid}, 6'b0);
      if (i == 3) grant = '0;
      step();
    end
    check("t4_wait", dbg_state, WAIT_GRANT);
    check("t4_req0", req, 4'b0001);

    // Timeout: grant held 0 with client 0 pending.
    tmo_at = 0;
    for (int k = 1; k <= 100; k++) begin
      if (timeout) begin
        tmo_at = k;
        break;
      end
      step();
    end
    check("t5_tmo_cycle", tmo_at, 64);
    check("t5_tmo_excl", {done, grant_err}, 2'b00);
    step();
    check("t5_guard", {dbg_state, req}, {GUARD, 4'b0000});
    check("t5_ptr_kept", ptr, 2'd2);
    step(); step(); step(); step();
    check("t5_rewait", {dbg_state, req}, {WAIT_GRANT, 4'b0001});
    check("t5_ptr_still", ptr, 2'd2);

    // Reset in the middle of a 16-beat burst on client 2.
    job_len[8 +: 4] = 4'd15;
    job_valid = 4'b0100;
    step();
    job_valid = '0;
    check("t6_req", req, 4'b0101);
    grant = 4'b0100;
    step();
    grant = '0;
    check("t6_owner", {owner_valid, owner_id}, 3'b110);
    step(); step(); step(); step();
    check("t6_beat5", {beat, done}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("t6_async_outs", {beat, done, owner_valid, owner_id, req, ptr}, 11'b0);
    check("t6_async_ready", job_ready, 4'b1111);
    n_done = 0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) n_done++;
      step();
    end
    check("t6_no_done", n_done, 0);
    check("t6_ready_after", job_ready, 4'b1111);
    check("t6_idle_after", dbg_state, IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
